// File: rtl/g729_pkg.sv
// Shared G.729 basic-op types, saturation limits and the saturating add/subtract
// used by every lane that combines two long words.
package g729_pkg;

  typedef logic signed [15:0] word_t;
  typedef logic signed [31:0] long_t;

  typedef struct packed {
    long_t value;
    logic  ovf;
  } satRes_t;

  localparam long_t MAX_32 = 32'h7FFFFFFF;
  localparam long_t MIN_32 = 32'h80000000;
  localparam word_t MAX_16 = 16'h7FFF;
  localparam word_t MIN_16 = 16'h8000;

  // Subtraction overflows when the operands differ in sign and the result
  // leaves a's sign; the saturation direction always follows a.
  function automatic satRes_t satAddSub(input long_t a, input long_t b, input logic sub);
    satRes_t r;
    long_t   s;
    s = sub ? (a - b) : (a + b);
    if (sub) r.ovf = (a[31] != b[31]) && (s[31] != a[31]);
    else     r.ovf = (a[31] == b[31]) && (s[31] != a[31]);
    r.value = r.ovf ? (a[31] ? MIN_32 : MAX_32) : s;
    return r;
  endfunction

endpackage

// File: rtl/g729_mult_sat.sv
// Combinational G.729 L_mult: signed 16x16 product doubled, saturated to 32 bits.
module g729_mult_sat
  import g729_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product,
  output logic        overflow
);

  long_t rawProduct;

  // The product of two 16-bit words always fits in 32 bits; only the doubling
  // can overflow, and only for MIN_16 * MIN_16.
  always_comb begin
    rawProduct = long_t'(word_t'(a)) * long_t'(word_t'(b));
    overflow   = (a == MIN_16) && (b == MIN_16);
    product    = overflow ? MAX_32 : (rawProduct <<< 1);
  end

endmodule

// File: rtl/g729_l_arith.sv
// Registered G.729 L_add / L_mult / L_msu lanes, computed in parallel with one
// cycle of latency; result registers hold when no new operands arrive.
module g729_l_arith
  import g729_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  input  logic [15:0] mult_a,
  input  logic [15:0] mult_b,
  input  logic [15:0] msu_a,
  input  logic [15:0] msu_b,
  input  logic [31:0] msu_c,
  output logic        out_valid,
  output logic [31:0] add_sum,
  output logic        add_overflow,
  output logic [31:0] mult_product,
  output logic        mult_overflow,
  output logic [31:0] msu_out,
  output logic        msu_overflow
);

  logic [31:0] multProd;
  logic        multOvf;
  logic [31:0] msuProd;
  logic        msuMultOvf;
  satRes_t     addRes;
  satRes_t     subRes;

  g729_mult_sat uMult (
    .a        (mult_a),
    .b        (mult_b),
    .product  (multProd),
    .overflow (multOvf)
  );

  g729_mult_sat uMsuMult (
    .a        (msu_a),
    .b        (msu_b),
    .product  (msuProd),
    .overflow (msuMultOvf)
  );

  always_comb begin
    addRes = satAddSub(add_a, add_b, 1'b0);
    subRes = satAddSub(msu_c, msuProd, 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      add_sum       <= '0;
      add_overflow  <= 1'b0;
      mult_product  <= '0;
      mult_overflow <= 1'b0;
      msu_out       <= '0;
      msu_overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        add_sum       <= addRes.value;
        add_overflow  <= addRes.ovf;
        mult_product  <= multProd;
        mult_overflow <= multOvf;
        msu_out       <= subRes.value;
        msu_overflow  <= msuMultOvf | subRes.ovf;
      end
    end
  end

endmodule

// File: tb/tb_g729_l_arith.sv
// Self-checking bench for g729_l_arith: directed corner cases, pipeline timing,
// async reset, then randomized traffic against a wide-integer reference model.
module tb_g729_l_arith;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] add_a, add_b, msu_c;
  logic [15:0] mult_a, mult_b, msu_a, msu_b;
  logic        out_valid;
  logic [31:0] add_sum, mult_product, msu_out;
  logic        add_overflow, mult_overflow, msu_overflow;

  int totalChecks = 0;
  int badChecks   = 0;

  // Expected register contents, updated only when a valid operand set is applied.
  logic        expValid;
  logic [31:0] expAdd, expMult, expMsu;
  logic        expAddOvf, expMultOvf, expMsuOvf;

  g729_l_arith dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .add_a         (add_a),
    .add_b         (add_b),
    .mult_a        (mult_a),
    .mult_b        (mult_b),
    .msu_a         (msu_a),
    .msu_b         (msu_b),
    .msu_c         (msu_c),
    .out_valid     (out_valid),
    .add_sum       (add_sum),
    .add_overflow  (add_overflow),
    .mult_product  (mult_product),
    .mult_overflow (mult_overflow),
    .msu_out       (msu_out),
    .msu_overflow  (msu_overflow)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: compute exactly in 64 bits, then clamp to 32 bits.
  function automatic void clamp32(input longint v, output logic [31:0] r, output logic o);
    o = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    if (!o)        r = v[31:0];
    else if (v > 0) r = 32'h7FFFFFFF;
    else           r = 32'h80000000;
  endfunction

  function automatic void modelMult(input logic [15:0] a, input logic [15:0] b,
                                    output logic [31:0] r, output logic o);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) * 2;
    clamp32(p, r, o);
  endfunction

  function automatic void modelAdd(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic o);
    clamp32(longint'($signed(a)) + longint'($signed(b)), r, o);
  endfunction

  function automatic void modelMsu(input logic [31:0] c, input logic [15:0] a, input logic [15:0] b,
                                   output logic [31:0] r, output logic o);
    logic [31:0] m;
    logic        mo, so;
    modelMult(a, b, m, mo);
    clamp32(longint'($signed(c)) - longint'($signed(m)), r, so);
    o = mo | so;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"},    {31'b0, out_valid},     {31'b0, expValid});
    checkOutput({tag, ".add"},      add_sum,                expAdd);
    checkOutput({tag, ".addOvf"},   {31'b0, add_overflow},  {31'b0, expAddOvf});
    checkOutput({tag, ".mult"},     mult_product,           expMult);
    checkOutput({tag, ".multOvf"},  {31'b0, mult_overflow}, {31'b0, expMultOvf});
    checkOutput({tag, ".msu"},      msu_out,                expMsu);
    checkOutput({tag, ".msuOvf"},   {31'b0, msu_overflow},  {31'b0, expMsuOvf});
  endtask

  task automatic clearExpected();
    expValid = 0; expAdd = 0; expMult = 0; expMsu = 0;
    expAddOvf = 0; expMultOvf = 0; expMsuOvf = 0;
  endtask

  // Drive one operand set at the falling edge and check the registered result
  // just after the following rising edge.
  task automatic applyStimulus(input string tag, input logic v,
                               input logic [31:0] aa, input logic [31:0] ab,
                               input logic [15:0] ma, input logic [15:0] mb,
                               input logic [15:0] sa, input logic [15:0] sb,
                               input logic [31:0] sc);
    @(negedge clk);
    in_valid = v; add_a = aa; add_b = ab; mult_a = ma; mult_b = mb;
    msu_a = sa; msu_b = sb; msu_c = sc;
    expValid = v;
    if (v) begin
      modelAdd(aa, ab, expAdd, expAddOvf);
      modelMult(ma, mb, expMult, expMultOvf);
      modelMsu(sc, sa, sb, expMsu, expMsuOvf);
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  function automatic logic [15:0] pickWord();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pickLong();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'h7FFFFFFF;
      2: return 32'hFFFFFFFF;
      3: return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1; in_valid = 0;
    add_a = 0; add_b = 0; mult_a = 0; mult_b = 0; msu_a = 0; msu_b = 0; msu_c = 0;
    clearExpected();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    reset = 0;

    // Directed rows: each lane gets its own corner case in the same cycle.
    applyStimulus("d0", 1, 32'h00001000, 32'h00002000, 16'h4000, 16'h4000, 16'h0002, 16'h0003, 32'h00010000);
    applyStimulus("d1", 1, 32'h7FFFFFFF, 32'h00000001, 16'hFFFF, 16'h0002, 16'h8000, 16'h8000, 32'h00000000);
    applyStimulus("d2", 1, 32'h80000000, 32'hFFFFFFFF, 16'h8000, 16'h8000, 16'h4000, 16'h4000, 32'h80000000);
    applyStimulus("d3", 1, 32'h7FFFFFFF, 32'h80000000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 32'h7FFFFFFF);

    // Spot checks against hand-computed values for the corner rows above.
    checkOutput("d3.addConst",  add_sum,      32'hFFFFFFFF);
    checkOutput("d3.multConst", mult_product, 32'h80010000);
    checkOutput("d3.msuConst",  msu_out,      32'h7FFFFFFF);

    // Hold: with in_valid low the last results remain and out_valid drops.
    applyStimulus("hold0", 0, 32'h12345678, 32'h11111111, 16'h1234, 16'h4321, 16'h0101, 16'h0202, 32'h55555555);
    applyStimulus("hold1", 0, 32'h00000005, 32'h00000006, 16'h0007, 16'h0008, 16'h0009, 16'h000A, 32'h0000000B);

    // Asynchronous reset between edges while operands are valid.
    @(negedge clk);
    in_valid = 1; add_a = 32'h00000100; add_b = 32'h00000200;
    mult_a = 16'h0100; mult_b = 16'h0200; msu_a = 16'h0003; msu_b = 16'h0004; msu_c = 32'h00001000;
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    clearExpected();
    checkAll("asyncRst");
    @(posedge clk);
    #1;
    checkAll("rstHeld");
    @(negedge clk);
    reset = 0; in_valid = 0;
    applyStimulus("postRst0", 0, 32'h00000001, 32'h00000002, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 32'h00000001);
    applyStimulus("postRst1", 0, 32'h00000001, 32'h00000002, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 32'h00000001);
    applyStimulus("postRst2", 1, 32'h00000001, 32'h00000002, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 32'h00000001);

    // Randomized traffic with mixed valid and back-to-back operation.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", ($urandom_range(0, 3) != 0), pickLong(), pickLong(),
                    pickWord(), pickWord(), pickWord(), pickWord(), pickLong());
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
